// File: rtl/ball_read.sv
// ball_read: decodes and qualifies the 8x8 LED-matrix ball drive bus into an
// X/Y coordinate stream. Optional error counter is built with BALL_READ_ERRCNT_EN.
module ball_read #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       sx_in,
  input  logic [7:0]       sy_in,
  output logic             pos_valid,
  input  logic             pos_ready,
  output logic [2:0]       pos_x,
  output logic [2:0]       pos_y,
  output logic             blank,
  output logic             enc_err,
  output logic [ERR_W-1:0] err_count
);

  // state  | meaning
  // Q_IDLE | bus blank or malformed, nothing being qualified
  // Q_QUAL | a valid code is being counted towards STABLE_CYCLES
  // Q_LOCK | code already reported, held without further reports
  typedef enum logic [1:0] {Q_IDLE, Q_QUAL, Q_LOCK} state_t;

  localparam logic [8:0] STABLE_M = STABLE_CYCLES[8:0];

  logic [7:0] s_x, s_y;
  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [8:0] cnt_p1;
  logic [2:0] code_x, code_y, code_x_nxt, code_y_nxt;
  logic [2:0] dec_x, dec_y;
  logic       cls_valid, cls_blank;
  logic       same_code, new_code, report, hs;
  logic [2:0] pend_x, pend_y;
  logic       pend_v;

  function automatic logic [2:0] idx8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = i[2:0];
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      s_x <= 8'h00;
      s_y <= 8'hFF;
    end else begin
      s_x <= sx_in;
      s_y <= sy_in;
    end
  end

  always_comb begin
    cls_blank = (s_x == 8'h00) || (s_y == 8'hFF);
    cls_valid = !cls_blank && $onehot(s_x) && $onehot(~s_y);
    dec_x     = idx8(s_x);
    dec_y     = idx8(~s_y);
    same_code = (dec_x == code_x) && (dec_y == code_y);
    new_code  = (state == Q_IDLE) || !same_code;
    cnt_p1    = {1'b0, cnt} + 9'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= Q_IDLE;
      cnt    <= 8'd0;
      code_x <= 3'd0;
      code_y <= 3'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      code_x <= code_x_nxt;
      code_y <= code_y_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    code_x_nxt = code_x;
    code_y_nxt = code_y;
    if (!cls_valid) begin
      state_nxt = Q_IDLE;
      cnt_nxt   = 8'd0;
    end else if (new_code) begin
      code_x_nxt = dec_x;
      code_y_nxt = dec_y;
      cnt_nxt    = 8'd1;
      state_nxt  = (STABLE_CYCLES == 1) ? Q_LOCK : Q_QUAL;
    end else if (state == Q_QUAL) begin
      cnt_nxt   = cnt_p1[7:0];
      state_nxt = (cnt_p1 == STABLE_M) ? Q_LOCK : Q_QUAL;
    end
  end

  always_comb begin
    blank   = cls_blank;
    enc_err = !cls_blank && !cls_valid;
    report  = 1'b0;
    if (cls_valid) begin
      if (new_code) report = (STABLE_CYCLES == 1);
      else          report = (state == Q_QUAL) && (cnt_p1 == STABLE_M);
    end
  end

  assign hs = pos_valid & pos_ready;

  // Output slot plus one pending slot; a newer report replaces the pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_valid <= 1'b0;
      pos_x     <= 3'd0;
      pos_y     <= 3'd0;
      pend_v    <= 1'b0;
      pend_x    <= 3'd0;
      pend_y    <= 3'd0;
    end else if (!pos_valid || hs) begin
      if (report) begin
        pos_valid <= 1'b1;
        pos_x     <= dec_x;
        pos_y     <= dec_y;
        pend_v    <= 1'b0;
      end else if (pend_v) begin
        pos_valid <= 1'b1;
        pos_x     <= pend_x;
        pos_y     <= pend_y;
        pend_v    <= 1'b0;
      end else begin
        pos_valid <= 1'b0;
      end
    end else if (report) begin
      pend_v <= 1'b1;
      pend_x <= dec_x;
      pend_y <= dec_y;
    end
  end

`ifdef BALL_READ_ERRCNT_EN
  logic [ERR_W-1:0] err_q;

  always_ff @(posedge clk) begin
    if (rst)                          err_q <= '0;
    else if (enc_err && (err_q != '1)) err_q <= err_q + 1'b1;
  end

  assign err_count = err_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_ball_read.sv
// Self-checking bench for ball_read: per-scenario tasks plus a coordinate
// scoreboard that is checked on every output handshake.
module tb_ball_read;

  localparam int ERR_W = 8;
`ifdef BALL_READ_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic [7:0]       sx_in, sy_in;
  logic             pos_valid, pos_ready;
  logic [2:0]       pos_x, pos_y;
  logic             blank, enc_err;
  logic [ERR_W-1:0] err_count;

  int n_checks;
  int n_errors;
  logic [5:0] exp_q[$];

  ball_read #(.STABLE_CYCLES(4), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .sx_in(sx_in), .sy_in(sy_in),
    .pos_valid(pos_valid), .pos_ready(pos_ready),
    .pos_x(pos_x), .pos_y(pos_y),
    .blank(blank), .enc_err(enc_err), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && pos_valid && pos_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got (%0d,%0d) with no coordinate expected", pos_x, pos_y);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if ({pos_x, pos_y} !== e) begin
          n_errors++;
          $display("FAIL sb_coord: got (%0d,%0d) want (%0d,%0d)", pos_x, pos_y, e[5:3], e[2:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] x, input logic [7:0] y);
    sx_in = x;
    sy_in = y;
  endtask

  task automatic bus_blank(input int n);
    drive(8'h00, 8'hFF);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; pos_ready = 1'b0; drive(8'h00, 8'hFF);
    step();
    step();
    n_checks++;
    if ({pos_valid, pos_x, pos_y, enc_err, blank} !== 9'b0_000_000_0_1) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%0b x=%0d y=%0d err=%0b blank=%0b want v=0 x=0 y=0 err=0 blank=1",
               pos_valid, pos_x, pos_y, enc_err, blank);
    end
    n_checks++;
    if (err_count !== '0) begin
      n_errors++;
      $display("FAIL reset_errcnt: got %0d want 0", err_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    pos_ready = 1'b1;
    drive(8'h08, 8'hEF);
    exp_q.push_back({3'd3, 3'd4});
    for (int e = 0; e < 10; e++) begin
      step();
      n_checks++;
      if (pos_valid !== 1'(e == 4)) begin
        n_errors++;
        $display("FAIL basic_valid edge %0d: got %0b want %0b", e, pos_valid, (e == 4));
      end
    end
    bus_blank(3);
  endtask

  task automatic test_toggle();
    pos_ready = 1'b1;
    for (int e = 0; e < 16; e++) begin
      if (((e / 2) % 2) == 0) drive(8'h04, 8'hFD);
      else                    drive(8'h20, 8'hBF);
      step();
      n_checks++;
      if (pos_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL toggle_valid edge %0d: got %0b want 0", e, pos_valid);
      end
    end
    bus_blank(3);
  endtask

  task automatic test_enc_err();
    pos_ready = 1'b1;
    drive(8'h18, 8'hEF);
    for (int e = 0; e < 3; e++) begin
      step();
      n_checks++;
      if ({enc_err, blank, pos_valid} !== 3'b100) begin
        n_errors++;
        $display("FAIL encerr_flags edge %0d: got err=%0b blank=%0b v=%0b want 1 0 0", e, enc_err, blank, pos_valid);
      end
    end
    drive(8'h00, 8'hFF);
    step();
    n_checks++;
    if (enc_err !== 1'b0) begin
      n_errors++;
      $display("FAIL encerr_clear: got %0b want 0", enc_err);
    end
    n_checks++;
    if (err_count !== (ERRCNT ? ERR_W'(3) : ERR_W'(0))) begin
      n_errors++;
      $display("FAIL encerr_count: got %0d want %0d", err_count, ERRCNT ? 3 : 0);
    end
    bus_blank(2);
  endtask

  task automatic test_backpressure();
    pos_ready = 1'b0;
    drive(8'h02, 8'hFD);
    exp_q.push_back({3'd1, 3'd1});
    for (int e = 0; e < 6; e++) begin
      step();
      n_checks++;
      if (pos_valid !== 1'(e >= 4)) begin
        n_errors++;
        $display("FAIL bp_first edge %0d: got %0b want %0b", e, pos_valid, (e >= 4));
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (p == 0) drive(8'h40, 8'hFB);
      else        drive(8'h80, 8'hFE);
      for (int e = 0; e < 6; e++) begin
        step();
        n_checks++;
        if ({pos_valid, pos_x, pos_y} !== {1'b1, 3'd1, 3'd1}) begin
          n_errors++;
          $display("FAIL bp_hold phase %0d edge %0d: got v=%0b (%0d,%0d) want v=1 (1,1)", p, e, pos_valid, pos_x, pos_y);
        end
      end
    end
    exp_q.push_back({3'd7, 3'd0});
    pos_ready = 1'b1;
    step();
    n_checks++;
    if ({pos_valid, pos_x, pos_y} !== {1'b1, 3'd7, 3'd0}) begin
      n_errors++;
      $display("FAIL bp_pending: got v=%0b (%0d,%0d) want v=1 (7,0)", pos_valid, pos_x, pos_y);
    end
    step();
    n_checks++;
    if (pos_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_drain: got %0b want 0", pos_valid);
    end
    bus_blank(3);
  endtask

  task automatic test_blank_gap();
    pos_ready = 1'b1;
    drive(8'h10, 8'hEF);
    exp_q.push_back({3'd4, 3'd4});
    for (int e = 0; e < 6; e++) begin
      step();
      n_checks++;
      if (pos_valid !== 1'(e == 4)) begin
        n_errors++;
        $display("FAIL gap_first edge %0d: got %0b want %0b", e, pos_valid, (e == 4));
      end
    end
    sx_in = 8'h00;
    step();
    n_checks++;
    if ({blank, pos_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL gap_blank: got blank=%0b v=%0b want 1 0", blank, pos_valid);
    end
    drive(8'h10, 8'hEF);
    exp_q.push_back({3'd4, 3'd4});
    for (int e = 1; e < 8; e++) begin
      step();
      n_checks++;
      if ({blank, pos_valid} !== {1'b0, 1'(e == 5)}) begin
        n_errors++;
        $display("FAIL gap_second edge %0d: got blank=%0b v=%0b want 0 %0b", e, blank, pos_valid, (e == 5));
      end
    end
    bus_blank(3);
  endtask

  task automatic test_saturate();
    drive(8'h18, 8'hEF);
    repeat (270) step();
    drive(8'h00, 8'hFF);
    step();
    step();
    n_checks++;
    if (err_count !== (ERRCNT ? {ERR_W{1'b1}} : ERR_W'(0))) begin
      n_errors++;
      $display("FAIL sat_count: got %0d want %0d", err_count, ERRCNT ? (1 << ERR_W) - 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    pos_ready = 1'b0;
    drive(8'h04, 8'hDF);
    repeat (6) step();
    n_checks++;
    if ({pos_valid, pos_x, pos_y} !== {1'b1, 3'd2, 3'd5}) begin
      n_errors++;
      $display("FAIL rmid_out: got v=%0b (%0d,%0d) want v=1 (2,5)", pos_valid, pos_x, pos_y);
    end
    drive(8'h01, 8'h7F);
    repeat (6) step();
    rst = 1'b1;
    drive(8'h00, 8'hFF);
    step();
    n_checks++;
    if ({pos_valid, blank} !== 2'b01) begin
      n_errors++;
      $display("FAIL rmid_flags: got v=%0b blank=%0b want 0 1", pos_valid, blank);
    end
    n_checks++;
    if (err_count !== '0) begin
      n_errors++;
      $display("FAIL rmid_errcnt: got %0d want 0", err_count);
    end
    rst = 1'b0;
    pos_ready = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      n_checks++;
      if (pos_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rmid_nodeliver edge %0d: got %0b want 0", e, pos_valid);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; pos_ready = 1'b0; sx_in = 8'h00; sy_in = 8'hFF;
    test_reset();
    test_basic();
    test_toggle();
    test_enc_err();
    test_backpressure();
    test_blank_gap();
    test_saturate();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL sb_leftover: got %0d undelivered want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ball_read.md
# ball_read

Decoder and qualifier for the 8x8 LED-matrix ball drive bus. The block samples a one-hot column bus and an active-low one-hot row bus and checks the encoding. After the pattern is stable for a configurable time, it recovers the 3-bit X/Y ball coordinate and delivers it over a valid/ready handshake, with one level of buffering. It sits on the display side of the matrix interface and is used for position readback, the self-check monitor and the score/collision logic.

## Interface
- STABLE_CYCLES, 4: consecutive identical valid samples required before a coordinate is reported; legal range 1..255.
- ERR_W, 8: width of the error counter.
- clk  in  1: single clock; all logic is on the rising edge.
- rst  in  1: synchronous, active-high reset.
- sx_in  in  8: column select, one-hot, active-high; bit n is column X=n.
- sy_in  in  8: row select, one-hot, active-low; a cleared bit n is row Y=n.
- pos_valid  out  1: a coordinate is presented on pos_x/pos_y.
- pos_ready  in  1: the consumer accepts the coordinate.
- pos_x  out  3: decoded column index.
- pos_y  out  3: decoded row index.
- blank  out  1: the registered sample has sx==8'h00 or sy==8'hFF.
- enc_err  out  1: the registered sample is a malformed encoding.
- err_count  out  ERR_W: saturating count of enc_err cycles.

## Operation
- Input stage: sx_in and sy_in are registered once into s_x and s_y. All decoding uses s_x/s_y.
- Decode classes for the registered sample:
  - VALID: s_x has exactly one bit set and s_y has exactly one bit clear. X is the index of the set bit; Y is the index of the clear bit.
  - BLANK: s_x==0 or s_y==8'hFF. This is not an error.
  - INVALID: anything else, e.g. two columns set or two rows cleared.
- State machine with states Q_IDLE, Q_QUAL and Q_LOCK:
  - Q_IDLE: entered on BLANK or INVALID. A VALID sample moves to Q_QUAL and sets the stability counter to 1.
  - Q_QUAL: if the sample is VALID and equal to the previous sample, the counter increments. When it reaches STABLE_CYCLES, the coordinate is reported and the state moves to Q_LOCK. A different VALID code restarts the count at 1. BLANK or INVALID returns to Q_IDLE.
  - Q_LOCK: the same code holds with no further reports. A different VALID code moves to Q_QUAL with the count at 1. BLANK or INVALID moves to Q_IDLE.
  - If STABLE_CYCLES==1, a VALID sample in Q_IDLE reports immediately and the state moves to Q_LOCK.
- Output buffering uses an output register and one pending register:
  - A report with the output slot empty, or being accepted in the same cycle, loads the output register.
  - A report while the output is stalled (pos_valid=1, pos_ready=0) goes to the pending register. A newer report overwrites any older pending value; the latest coordinate wins.
  - On a handshake (pos_valid & pos_ready) with pending full, the pending value moves to the output and pos_valid stays 1. With pending empty, pos_valid drops unless a report arrives in the same cycle.
- enc_err equals (class==INVALID). err_count adds 1 on every enc_err cycle and saturates at all-ones.
- Reset values:
  - pos_valid=0, pos_x=0, pos_y=0, enc_err=0, err_count=0.
  - s_x=0 and s_y=8'hFF, so blank=1 after reset.
  - State is Q_IDLE, the counter is 0 and pending is empty.
- A reset asserted mid-operation discards the output and pending coordinates. The next edge after reset is released samples the inputs normally.

## Timing
- There is one register of input latency. blank and enc_err reflect inputs from one edge earlier.
- Suppose a VALID pattern is applied before edge 0 and held. It is registered at edge 0, and pos_valid is high after edge STABLE_CYCLES. With STABLE_CYCLES=4, pos_valid is high after edge 4.
- Once asserted, pos_valid, pos_x and pos_y hold until the handshake edge. Nothing changes while stalled.
- A report and a handshake in the same cycle: the report loads the output directly and the output stays valid.
- pos_ready is ignored while pos_valid=0.

## Configuration
- BALL_READ_ERRCNT_EN:
  - Defined: err_count counts as described above.
  - Undefined: err_count is constant 0 and no counter flops are built. enc_err still operates. The port list is unchanged.

## Test plan
- STABLE_CYCLES=4, pos_ready=1, sx_in=8'h08, sy_in=8'hEF held from before edge 0 -> pos_valid=1 with pos_x=3, pos_y=4 after edge 4, for exactly one cycle; no further reports while the pattern is held.
- Code toggles between X=2,Y=1 and X=5,Y=6 every 2 cycles with STABLE_CYCLES=4 -> pos_valid never asserts.
- sx_in=8'h18 for 3 cycles -> enc_err=1 for 3 cycles, err_count=3 (0 with macro undefined), blank=0, no report.
- Report X=1,Y=1 with pos_ready=0, then X=6,Y=2, then X=7,Y=0 qualify -> output holds (1,1); raising pos_ready gives (1,1) then (7,0); (6,2) is dropped.
- After X=4,Y=4 is reported, sx_in=0 for 1 cycle, then X=4,Y=4 again -> blank=1 for one cycle and a second report of (4,4) after STABLE_CYCLES more edges.
- rst asserted for one cycle while an output and a pending coordinate are held -> pos_valid=0, err_count=0 and blank=1 after the reset edge, and the pending coordinate is never delivered.
